// File: rtl/tpumac_pipe.sv
// Two-stage signed multiply-accumulate cell for a systolic array.
// Optional saturating accumulator: define TPUMAC_SAT_EN (default build wraps).
module tpumac_pipe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      vld_out,
  output logic                      ovf
);

  localparam int PW = 2 * BITS_AB;

  logic signed [BITS_AB-1:0] a_p1_q, a_p1_d;
  logic signed [BITS_AB-1:0] b_p1_q, b_p1_d;
  logic signed [PW-1:0]      prod_p1_q, prod_p1_d;
  logic                      vld_p1_q, vld_p1_d;
  logic signed [BITS_C-1:0]  acc_p2_q, acc_p2_d;
  logic                      vld_p2_q, vld_p2_d;
  logic                      ovf_q, ovf_d;

  logic                      cap;
  logic signed [BITS_C-1:0]  sum;
  logic                      sum_ovf;

  // Clamp a one-bit-wider sum back into the accumulator range.
  function automatic logic signed [BITS_C-1:0] sat_sum(input logic signed [BITS_C:0] s);
    logic signed [BITS_C-1:0] r;
    if (s[BITS_C] != s[BITS_C-1]) begin
      r = s[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end else begin
      r = s[BITS_C-1:0];
    end
    return r;
  endfunction

  function automatic logic sum_overflow(input logic signed [BITS_C:0] s);
    return s[BITS_C] ^ s[BITS_C-1];
  endfunction

  assign cap = en & ~WrEn & ~clr;

  // Stage 1: operand capture and product
  always_comb begin
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    prod_p1_d = prod_p1_q;
    vld_p1_d  = 1'b0;
    if (cap) begin
      a_p1_d    = Ain;
      b_p1_d    = Bin;
      prod_p1_d = PW'(Ain) * PW'(Bin);
      vld_p1_d  = 1'b1;
    end
  end

  // Stage 2: accumulate
`ifdef TPUMAC_SAT_EN
  logic signed [BITS_C:0] sum_wide;
  always_comb begin
    sum_wide = (BITS_C+1)'(acc_p2_q) + (BITS_C+1)'(prod_p1_q);
    sum      = sat_sum(sum_wide);
    sum_ovf  = sum_overflow(sum_wide);
  end
`else
  always_comb begin
    sum     = acc_p2_q + BITS_C'(prod_p1_q);
    sum_ovf = 1'b0;
  end
`endif

  always_comb begin
    acc_p2_d = acc_p2_q;
    vld_p2_d = 1'b0;
    ovf_d    = ovf_q;
    if (clr) begin
      acc_p2_d = '0;
      ovf_d    = 1'b0;
    end else if (WrEn) begin
      acc_p2_d = Cin;
    end else if (vld_p1_q) begin
      acc_p2_d = sum;
      vld_p2_d = 1'b1;
      ovf_d    = ovf_q | sum_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      prod_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      acc_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      prod_p1_q <= prod_p1_d;
      vld_p1_q  <= vld_p1_d;
      acc_p2_q  <= acc_p2_d;
      vld_p2_q  <= vld_p2_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Aout    = a_p1_q;
  assign Bout    = b_p1_q;
  assign Cout    = acc_p2_q;
  assign vld_out = vld_p2_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_tpumac_pipe.sv
// Scoreboard bench for tpumac_pipe: accumulation results are queued at issue
// and checked by a monitor on each vld_out pulse; non-accumulating cycles are checked inline.
module tb_tpumac_pipe;

  logic               clk = 1'b0;
  logic               rst, en, WrEn, clr;
  logic signed [7:0]  Ain, Bin;
  logic signed [15:0] Cin;
  logic signed [7:0]  Aout, Bout;
  logic signed [15:0] Cout;
  logic               vld_out, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  longint sb[$];

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16)) dut (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(Aout), .Bout(Bout), .Cout(Cout), .vld_out(vld_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every vld_out pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (vld_out === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_vld: got Cout=%0d expected no pulse", Cout);
      end else begin
        longint e;
        e = sb.pop_front();
        if (longint'(Cout) != e) begin
          n_bad++;
          $display("FAIL sb_cout: got %0d expected %0d", Cout, e);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic w, input logic c,
                     input int a, input int b, input int ci);
    rst = r; en = e; WrEn = w; clr = c;
    Ain = 8'(a); Bin = 8'(b); Cin = 16'(ci);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with live operands on the inputs
    cyc(1, 1, 0, 0, 5, 3, 0);
    check("rst_aout", Aout, 0);
    check("rst_bout", Bout, 0);
    check("rst_cout", Cout, 0);
    check("rst_vld", vld_out, 0);
    check("rst_ovf", ovf, 0);

    // Back-to-back accumulation: 12, 2, -5
    sb.push_back(12); cyc(0, 1, 0, 0, 3, 4, 0);
    sb.push_back(2);  cyc(0, 1, 0, 0, -2, 5, 0);
    sb.push_back(-5); cyc(0, 1, 0, 0, 7, -1, 0);
    check("acc_aout", Aout, 7);
    check("acc_bout", Bout, -1);
    check("acc_cout_mid", Cout, 2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("acc_cout_last", Cout, -5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("acc_vld_drop", vld_out, 0);
    check("acc_cout_hold", Cout, -5);

    // Load cancels an in-flight product
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("clr_cout", Cout, 0);
    cyc(0, 1, 0, 0, 10, 10, 0);
    cyc(0, 1, 1, 0, 1, 1, -100);
    check("ld_cout", Cout, -100);
    check("ld_vld", vld_out, 0);
    check("ld_aout", Aout, 10);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("ld_cout_after", Cout, -100);
    check("ld_vld_after", vld_out, 0);

    // clr beats WrEn
    cyc(0, 0, 1, 1, 0, 0, 55);
    check("prio_cout", Cout, 0);
    check("prio_ovf", ovf, 0);
    check("prio_aout", Aout, 10);

    // clr discards a pending product
    cyc(0, 1, 0, 0, 2, 3, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("clr_pend_cout", Cout, 0);
    check("clr_pend_vld", vld_out, 0);

    // Positive overflow
    cyc(0, 0, 1, 0, 0, 0, 32767);
`ifdef TPUMAC_SAT_EN
    sb.push_back(32767);
`else
    sb.push_back(-32768);
`endif
    cyc(0, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef TPUMAC_SAT_EN
    check("ovf_pos", ovf, 1);
`else
    check("ovf_pos", ovf, 0);
`endif
    // WrEn leaves ovf untouched; clr clears it
    cyc(0, 0, 1, 0, 0, 0, 0);
`ifdef TPUMAC_SAT_EN
    check("ovf_sticky", ovf, 1);
`else
    check("ovf_sticky", ovf, 0);
`endif
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("ovf_clr", ovf, 0);

    // Negative overflow: -32768 + (-1)
    cyc(0, 0, 1, 0, 0, 0, -32768);
`ifdef TPUMAC_SAT_EN
    sb.push_back(-32768);
`else
    sb.push_back(32767);
`endif
    cyc(0, 1, 0, 0, -1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // Stall: en 1,0,1 -> 4, 4, 13
    sb.push_back(4);  cyc(0, 1, 0, 0, 2, 2, 0);
    cyc(0, 0, 0, 0, 9, 9, 0);
    check("stall_cout", Cout, 4);
    sb.push_back(13); cyc(0, 1, 0, 0, 3, 3, 0);
    check("stall_vld_gap", vld_out, 0);
    check("stall_cout_hold", Cout, 4);
    check("stall_aout", Aout, 3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("stall_cout_end", Cout, 13);

    // Reset mid-accumulation drops the product
    cyc(0, 1, 0, 0, 5, 5, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_mid_cout", Cout, 0);
    check("rst_mid_aout", Aout, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_vld", vld_out, 0);
    check("rst_mid_cout2", Cout, 0);

    cyc(0, 0, 0, 0, 0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
